chiplib_pri_queue_push_arb: RTL and testbench

- Multi-channel push front end for the priority queue.
- Accepts independent valid/ready push streams on NumPorts channels and buffers each one in a small per-port FIFO.
- Arbitrates FIFO heads by priority, with round-robin tie-break, into the single queue push interface.
- A registered output stage holds the winning entry while the queue reports full.

---
 rtl/chiplib_pri_queue_push_arb.sv | 166 ++++++++++++++++
 tb/tb_chiplib_pri_queue_push_arb.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chiplib_pri_queue_push_arb.sv
// Multi-port push front end: per-port FIFOs, priority/round-robin arbiter, output stage.
// Optional starvation aging: define CHIPLIB_PRI_QUEUE_PUSH_AGING_EN.
module chiplib_pri_queue_push_arb #(
   parameter int DataWidth     = 64,
   parameter int PriorityWidth = 16,
   parameter int NumPorts      = 4,
   parameter int BufDepth      = 2,
   parameter int AgeLimit      = 15
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NumPorts*DataWidth-1:0]     push_data,
   input  logic [NumPorts*PriorityWidth-1:0] push_pri,
   input  logic [NumPorts-1:0]               push_valid,
   output logic [NumPorts-1:0]               push_ready,
   output logic                              queue_push_valid,
   output logic [DataWidth-1:0]              queue_push_data,
   output logic [PriorityWidth-1:0]          queue_push_pri,
   output logic [$clog2(NumPorts)-1:0]       queue_push_port,
   input  logic                              full
);

   localparam int PW = $clog2(NumPorts);
   localparam int AW = $clog2(BufDepth);
   localparam int CW = AW + 1;

   logic [DataWidth-1:0]     mem_data [NumPorts][BufDepth];
   logic [PriorityWidth-1:0] mem_pri  [NumPorts][BufDepth];
   logic [AW-1:0]            wr_ptr   [NumPorts];
   logic [AW-1:0]            rd_ptr   [NumPorts];
   logic [CW-1:0]            count    [NumPorts];

   logic [PriorityWidth-1:0] head_pri [NumPorts];
   logic [NumPorts-1:0]      nonempty;
   logic [NumPorts-1:0]      cand;
   logic [NumPorts-1:0]      push_en;
   logic [NumPorts-1:0]      pop_en;
   logic [PriorityWidth-1:0] best;
   logic [PW-1:0]            idx;
   logic [PW-1:0]            win;
   logic [PW-1:0]            rr_ptr;
   logic [PW-1:0]            rr_next;
   logic                     grant;
   logic                     load;
   logic                     take;

   logic                     out_valid;
   logic [DataWidth-1:0]     out_data;
   logic [PriorityWidth-1:0] out_pri;
   logic [PW-1:0]            out_port;

   assign load = ~out_valid | ~full;
   assign take = load & grant;
   assign rr_next = (win == PW'(NumPorts - 1)) ? '0 : win + 1'b1;

   assign queue_push_valid = out_valid & ~full;
   assign queue_push_data  = out_data;
   assign queue_push_pri   = out_pri;
   assign queue_push_port  = out_port;

   always_comb begin
      for (int i = 0; i < NumPorts; i++) begin
         push_ready[i] = rst_n && (count[i] != CW'(BufDepth));
         push_en[i]    = push_valid[i] && push_ready[i];
         pop_en[i]     = take && (win == PW'(i));
         nonempty[i]   = (count[i] != '0);
         head_pri[i]   = mem_pri[i][rd_ptr[i]];
      end
   end

`ifdef CHIPLIB_PRI_QUEUE_PUSH_AGING_EN
   localparam int GW = $clog2(AgeLimit + 1);

   logic [GW-1:0]       age [NumPorts];
   logic [NumPorts-1:0] starved;

   always_comb begin
      for (int i = 0; i < NumPorts; i++) begin
         starved[i] = nonempty[i] && (age[i] == GW'(AgeLimit));
      end
   end

   // Ages advance only on cycles that actually grant someone else.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NumPorts; i++) age[i] <= '0;
      end else begin
         for (int i = 0; i < NumPorts; i++) begin
            if (!nonempty[i] || pop_en[i]) begin
               age[i] <= '0;
            end else if (take && age[i] != GW'(AgeLimit)) begin
               age[i] <= age[i] + 1'b1;
            end
         end
      end
   end

   assign cand = (|starved) ? starved : nonempty;
`else
   assign cand = nonempty;
`endif

   // Strict compare keeps the first tied port found from rr_ptr upward.
   always_comb begin
      grant = 1'b0;
      win   = '0;
      best  = '0;
      idx   = '0;
      for (int k = 0; k < NumPorts; k++) begin
         idx = PW'((int'(rr_ptr) + k) % NumPorts);
         if (cand[idx] && (!grant || head_pri[idx] > best)) begin
            grant = 1'b1;
            win   = idx;
            best  = head_pri[idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NumPorts; i++) begin
         if (push_en[i]) begin
            mem_data[i][wr_ptr[i]] <= push_data[i*DataWidth +: DataWidth];
            mem_pri[i][wr_ptr[i]]  <= push_pri[i*PriorityWidth +: PriorityWidth];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NumPorts; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NumPorts; i++) begin
            if (push_en[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
            if (pop_en[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
            if (push_en[i] && !pop_en[i]) begin
               count[i] <= count[i] + 1'b1;
            end else if (!push_en[i] && pop_en[i]) begin
               count[i] <= count[i] - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_pri   <= '0;
         out_port  <= '0;
         rr_ptr    <= '0;
      end else if (load) begin
         out_valid <= grant;
         if (grant) begin
            out_data <= mem_data[win][rd_ptr[win]];
            out_pri  <= head_pri[win];
            out_port <= win;
            rr_ptr   <= rr_next;
         end
      end
   end

endmodule

// File: tb/tb_chiplib_pri_queue_push_arb.sv
// Directed bench for chiplib_pri_queue_push_arb (4 ports, depth 2).
// Aging scenario runs only when CHIPLIB_PRI_QUEUE_PUSH_AGING_EN is defined.
module tb_chiplib_pri_queue_push_arb;

   localparam int NP  = 4;
   localparam int DW  = 64;
   localparam int PRW = 16;
   localparam int BD  = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic [DW-1:0]   d [NP];
   logic [PRW-1:0]  p [NP];
   logic [NP*DW-1:0]  push_data;
   logic [NP*PRW-1:0] push_pri;
   logic [NP-1:0]   push_valid;
   logic [NP-1:0]   push_ready;
   logic            queue_push_valid;
   logic [DW-1:0]   queue_push_data;
   logic [PRW-1:0]  queue_push_pri;
   logic [1:0]      queue_push_port;
   logic            full;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NP; g++) begin : g_pack
      assign push_data[g*DW +: DW]   = d[g];
      assign push_pri[g*PRW +: PRW] = p[g];
   end

   chiplib_pri_queue_push_arb #(
      .DataWidth(DW), .PriorityWidth(PRW), .NumPorts(NP),
      .BufDepth(BD), .AgeLimit(3)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .push_data(push_data), .push_pri(push_pri),
      .push_valid(push_valid), .push_ready(push_ready),
      .queue_push_valid(queue_push_valid),
      .queue_push_data(queue_push_data),
      .queue_push_pri(queue_push_pri),
      .queue_push_port(queue_push_port),
      .full(full)
   );

   task automatic clear_inputs();
      push_valid = '0;
      full = 1'b0;
      for (int i = 0; i < NP; i++) begin
         d[i] = '0;
         p[i] = '0;
      end
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #2;
      vectors++;
      if (queue_push_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_valid got %0b want 0", queue_push_valid);
      end
      vectors++;
      if (push_ready !== 4'h0) begin
         miscompares++;
         $display("FAIL reset_ready got %h want 0", push_ready);
      end
      vectors++;
      if (queue_push_data !== 64'h0 || queue_push_pri !== 16'h0) begin
         miscompares++;
         $display("FAIL reset_data got %h/%h want 0/0", queue_push_data, queue_push_pri);
      end
      vectors++;
      if (queue_push_port !== 2'd0) begin
         miscompares++;
         $display("FAIL reset_port got %0d want 0", queue_push_port);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (push_ready !== 4'hF) begin
         miscompares++;
         $display("FAIL reset_release_ready got %h want f", push_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      int pulses;
      push_valid = 4'b0001;
      d[0] = 64'hA1;
      p[0] = 16'd5;
      @(posedge clk); #1 push_valid = '0;
      @(negedge clk);
      vectors++;
      if (queue_push_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL single_t1 got %0b want 0", queue_push_valid);
      end
      @(posedge clk); #1;
      @(negedge clk);
      vectors++;
      if (queue_push_valid !== 1'b1 || queue_push_data !== 64'hA1) begin
         miscompares++;
         $display("FAIL single_t2 got v=%0b d=%h want v=1 d=a1", queue_push_valid, queue_push_data);
      end
      vectors++;
      if (queue_push_port !== 2'd0 || queue_push_pri !== 16'd5) begin
         miscompares++;
         $display("FAIL single_tag got port=%0d pri=%0d want 0/5", queue_push_port, queue_push_pri);
      end
      pulses = 0;
      repeat (4) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (queue_push_valid) pulses++;
      end
      vectors++;
      if (pulses !== 0) begin
         miscompares++;
         $display("FAIL single_extra got %0d pulses want 0", pulses);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_priority();
      push_valid = 4'b1010;
      d[1] = 64'h11; p[1] = 16'd3;
      d[3] = 64'h33; p[3] = 16'd9;
      @(posedge clk); #1 push_valid = '0;
      @(posedge clk); #1;
      @(negedge clk);
      vectors++;
      if (queue_push_valid !== 1'b1 || queue_push_port !== 2'd3 || queue_push_data !== 64'h33) begin
         miscompares++;
         $display("FAIL prio_first got v=%0b port=%0d d=%h want 1/3/33",
                  queue_push_valid, queue_push_port, queue_push_data);
      end
      @(posedge clk); #1;
      @(negedge clk);
      vectors++;
      if (queue_push_valid !== 1'b1 || queue_push_port !== 2'd1 || queue_push_data !== 64'h11) begin
         miscompares++;
         $display("FAIL prio_second got v=%0b port=%0d d=%h want 1/1/11",
                  queue_push_valid, queue_push_port, queue_push_data);
      end
      @(posedge clk); #1;
      @(negedge clk);
      vectors++;
      if (queue_push_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL prio_idle got %0b want 0", queue_push_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_round_robin();
      logic [1:0]    ep;
      logic [DW-1:0] ed;
      do_reset();
      push_valid = 4'hF;
      for (int i = 0; i < NP; i++) begin
         d[i] = 64'(i);
         p[i] = 16'd7;
      end
      @(posedge clk); #1;
      for (int i = 0; i < NP; i++) d[i] = 64'h100 + 64'(i);
      @(posedge clk); #1 push_valid = '0;
      for (int j = 0; j < 8; j++) begin
         ep = 2'(j % 4);
         ed = 64'((j / 4) * 256 + (j % 4));
         @(negedge clk);
         vectors++;
         if (queue_push_valid !== 1'b1 || queue_push_port !== ep) begin
            miscompares++;
            $display("FAIL rr_grant%0d got v=%0b port=%0d want 1/%0d",
                     j, queue_push_valid, queue_push_port, ep);
         end
         vectors++;
         if (queue_push_data !== ed) begin
            miscompares++;
            $display("FAIL rr_data%0d got %h want %h", j, queue_push_data, ed);
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      vectors++;
      if (queue_push_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL rr_gap got %0b want 0", queue_push_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      logic [NP-1:0] r;
      int acc [NP];
      int seen [NP];
      int total;
      int port;
      logic [DW-1:0] ed;
      do_reset();
      full = 1'b1;
      push_valid = 4'hF;
      for (int i = 0; i < NP; i++) begin
         acc[i] = 0;
         seen[i] = 0;
         d[i] = (64'(i) << 32);
         p[i] = 16'd4;
      end
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         r = push_ready;
         vectors++;
         if (queue_push_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_valid_c%0d got 1 want 0", c);
         end
         if (c >= 5) begin
            vectors++;
            if (r !== 4'h0) begin
               miscompares++;
               $display("FAIL bp_ready_c%0d got %h want 0", c, r);
            end
         end
         @(posedge clk); #1;
         for (int i = 0; i < NP; i++) begin
            if (r[i]) begin
               acc[i]++;
               d[i] = (64'(i) << 32) | 64'(acc[i]);
            end
         end
      end
      full = 1'b0;
      push_valid = '0;
      total = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (queue_push_valid) begin
            port = int'(queue_push_port);
            ed = (64'(port) << 32) | 64'(seen[port]);
            vectors++;
            if (queue_push_data !== ed) begin
               miscompares++;
               $display("FAIL bp_drain%0d got %h want %h", total, queue_push_data, ed);
            end
            seen[port]++;
            total++;
         end
         @(posedge clk); #1;
      end
      vectors++;
      if (total !== 1 + 4 * BD) begin
         miscompares++;
         $display("FAIL bp_total got %0d want %0d", total, 1 + 4 * BD);
      end
      for (int i = 0; i < NP; i++) begin
         vectors++;
         if (seen[i] !== acc[i]) begin
            miscompares++;
            $display("FAIL bp_port%0d got %0d want %0d", i, seen[i], acc[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int stale;
      do_reset();
      full = 1'b1;
      push_valid = 4'b0111;
      for (int i = 0; i < NP; i++) begin
         d[i] = 64'hB0 + 64'(i);
         p[i] = 16'(i + 1);
      end
      @(posedge clk); #1 push_valid = 4'b0011;
      @(posedge clk); #1 push_valid = '0;
      @(negedge clk);
      vectors++;
      if (queue_push_port !== 2'd2 || queue_push_data !== 64'hB2) begin
         miscompares++;
         $display("FAIL mid_pre got port=%0d d=%h want 2/b2", queue_push_port, queue_push_data);
      end
      #1 rst_n = 1'b0;
      #1;
      vectors++;
      if (queue_push_valid !== 1'b0 || push_ready !== 4'h0) begin
         miscompares++;
         $display("FAIL mid_rst_ctl got v=%0b rdy=%h want 0/0", queue_push_valid, push_ready);
      end
      vectors++;
      if (queue_push_data !== 64'h0 || queue_push_pri !== 16'h0 || queue_push_port !== 2'd0) begin
         miscompares++;
         $display("FAIL mid_rst_data got %h/%h/%0d want 0/0/0",
                  queue_push_data, queue_push_pri, queue_push_port);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      full = 1'b0;
      @(negedge clk);
      vectors++;
      if (push_ready !== 4'hF) begin
         miscompares++;
         $display("FAIL mid_ready got %h want f", push_ready);
      end
      stale = 0;
      repeat (6) begin
         @(negedge clk);
         if (queue_push_valid) stale++;
         @(posedge clk); #1;
      end
      vectors++;
      if (stale !== 0) begin
         miscompares++;
         $display("FAIL mid_stale got %0d pushes want 0", stale);
      end
   endtask

`ifdef CHIPLIB_PRI_QUEUE_PUSH_AGING_EN
   task automatic test_aging();
      logic [1:0] ep;
      do_reset();
      push_valid = 4'b0101;
      d[0] = 64'hC0; p[0] = 16'hFFFF;
      d[2] = 64'hC2; p[2] = 16'd1;
      @(posedge clk); #1 push_valid = 4'b0001;
      for (int j = 0; j < 4; j++) begin
         ep = (j < 3) ? 2'd0 : 2'd2;
         @(posedge clk); #1;
         @(negedge clk);
         vectors++;
         if (queue_push_valid !== 1'b1 || queue_push_port !== ep) begin
            miscompares++;
            $display("FAIL aging_grant%0d got v=%0b port=%0d want 1/%0d",
                     j, queue_push_valid, queue_push_port, ep);
         end
      end
      push_valid = '0;
      repeat (4) @(posedge clk);
      #1;
   endtask
`endif

   initial begin
      clear_inputs();
      test_reset();
      test_single();
      test_priority();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
`ifdef CHIPLIB_PRI_QUEUE_PUSH_AGING_EN
      test_aging();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
